// File: rtl/axi_lite_reg_master.sv
// axi_lite_reg_master
// Purpose: AXI4-Lite initiator that turns one register-access command at a time
// (read or write) into an AXI4-Lite transaction toward a single config slave, with a
// per-transaction watchdog that aborts transactions the slave never completes.
// Ports:
//   SysClk_ClkIn / SysRstN_RstIn  clock, synchronous active-low reset
//   Cmd*                          command handshake (valid/ready, write flag, address, data)
//   Resp*                         result handshake (valid/ready, data, response code, timeout flag)
//   AxiWriteAddr* / AxiWriteData* / AxiWriteResp*   AXI4-Lite AW, W and B channels
//   AxiReadAddr* / AxiReadData*                     AXI4-Lite AR and R channels
// Parameter TimeoutCycles_Gen: busy cycles from command accept until abort, 0 disables.
module axi_lite_reg_master #(
    parameter logic [15:0] TimeoutCycles_Gen = 16'd1000
) (
    input  logic        SysClk_ClkIn,
    input  logic        SysRstN_RstIn,
    input  logic        CmdValid_ValIn,
    output logic        CmdReady_RdyOut,
    input  logic        CmdWrite_EnIn,
    input  logic [15:0] CmdAddress_AdrIn,
    input  logic [31:0] CmdData_DatIn,
    output logic        RespValid_ValOut,
    input  logic        RespReady_RdyIn,
    output logic [31:0] RespData_DatOut,
    output logic [1:0]  RespResponse_DatOut,
    output logic        RespTimeout_ErrOut,
    output logic        AxiWriteAddrValid_ValOut,
    input  logic        AxiWriteAddrReady_RdyIn,
    output logic [15:0] AxiWriteAddrAddress_AdrOut,
    output logic [2:0]  AxiWriteAddrProt_DatOut,
    output logic        AxiWriteDataValid_ValOut,
    input  logic        AxiWriteDataReady_RdyIn,
    output logic [31:0] AxiWriteDataData_DatOut,
    output logic [3:0]  AxiWriteDataStrobe_DatOut,
    input  logic        AxiWriteRespValid_ValIn,
    output logic        AxiWriteRespReady_RdyOut,
    input  logic [1:0]  AxiWriteRespResponse_DatIn,
    output logic        AxiReadAddrValid_ValOut,
    input  logic        AxiReadAddrReady_RdyIn,
    output logic [15:0] AxiReadAddrAddress_AdrOut,
    output logic [2:0]  AxiReadAddrProt_DatOut,
    input  logic        AxiReadDataValid_ValIn,
    output logic        AxiReadDataReady_RdyOut,
    input  logic [1:0]  AxiReadDataResponse_DatIn,
    input  logic [31:0] AxiReadDataData_DatIn
);

    localparam logic [2:0] IDLE_ST       = 3'd0;
    localparam logic [2:0] WRITE_ADDR_ST = 3'd1;
    localparam logic [2:0] WRITE_RESP_ST = 3'd2;
    localparam logic [2:0] READ_ADDR_ST  = 3'd3;
    localparam logic [2:0] READ_DATA_ST  = 3'd4;
    localparam logic [2:0] RESP_ST       = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        b_ready_q, b_ready_d;
    logic        ar_valid_q, ar_valid_d;
    logic        r_ready_q, r_ready_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strobe_q, strobe_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [1:0]  resp_resp_q, resp_resp_d;
    logic        resp_timeout_q, resp_timeout_d;
    logic [15:0] timer_q, timer_d;

    logic busy;
    logic expire;
    logic completing;
    logic aw_done;
    logic w_done;

    // Next-state logic; the watchdog abort is applied last so it overrides the
    // per-state transitions, except when a B/R handshake completes in the same cycle.
    always_comb begin
        state_d        = state_q;
        cmd_ready_d    = cmd_ready_q;
        aw_valid_d     = aw_valid_q;
        w_valid_d      = w_valid_q;
        b_ready_d      = b_ready_q;
        ar_valid_d     = ar_valid_q;
        r_ready_d      = r_ready_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        strobe_d       = 4'hF;
        resp_valid_d   = resp_valid_q;
        resp_data_d    = resp_data_q;
        resp_resp_d    = resp_resp_q;
        resp_timeout_d = resp_timeout_q;
        timer_d        = timer_q;

        busy = (state_q == WRITE_ADDR_ST) || (state_q == WRITE_RESP_ST) ||
               (state_q == READ_ADDR_ST)  || (state_q == READ_DATA_ST);
        expire = (TimeoutCycles_Gen != 16'd0) &&
                 (timer_q == (TimeoutCycles_Gen - 16'd1));
        completing = ((state_q == WRITE_RESP_ST) && b_ready_q && AxiWriteRespValid_ValIn) ||
                     ((state_q == READ_DATA_ST) && r_ready_q && AxiReadDataValid_ValIn);
        // A channel counts as done once its valid has been dropped after the handshake.
        aw_done = !aw_valid_q || AxiWriteAddrReady_RdyIn;
        w_done  = !w_valid_q || AxiWriteDataReady_RdyIn;

        if (busy && (timer_q != 16'hFFFF)) begin
            timer_d = timer_q + 16'd1;
        end

        case (state_q)
            IDLE_ST: begin
                if (cmd_ready_q && CmdValid_ValIn) begin
                    cmd_ready_d = 1'b0;
                    timer_d     = 16'd0;
                    addr_d      = CmdAddress_AdrIn;
                    wdata_d     = CmdData_DatIn;
                    if (CmdWrite_EnIn) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WRITE_ADDR_ST;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = READ_ADDR_ST;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            WRITE_ADDR_ST: begin
                if (aw_valid_q && AxiWriteAddrReady_RdyIn) aw_valid_d = 1'b0;
                if (w_valid_q && AxiWriteDataReady_RdyIn) w_valid_d = 1'b0;
                if (aw_done && w_done) begin
                    b_ready_d = 1'b1;
                    state_d   = WRITE_RESP_ST;
                end
            end
            WRITE_RESP_ST: begin
                if (b_ready_q && AxiWriteRespValid_ValIn) begin
                    b_ready_d      = 1'b0;
                    resp_resp_d    = AxiWriteRespResponse_DatIn;
                    resp_data_d    = 32'd0;
                    resp_timeout_d = 1'b0;
                    resp_valid_d   = 1'b1;
                    state_d        = RESP_ST;
                end
            end
            READ_ADDR_ST: begin
                if (AxiReadAddrReady_RdyIn) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = READ_DATA_ST;
                end
            end
            READ_DATA_ST: begin
                if (r_ready_q && AxiReadDataValid_ValIn) begin
                    r_ready_d      = 1'b0;
                    resp_resp_d    = AxiReadDataResponse_DatIn;
                    resp_data_d    = AxiReadDataData_DatIn;
                    resp_timeout_d = 1'b0;
                    resp_valid_d   = 1'b1;
                    state_d        = RESP_ST;
                end
            end
            RESP_ST: begin
                if (RespReady_RdyIn) begin
                    resp_valid_d = 1'b0;
                    cmd_ready_d  = 1'b1;
                    state_d      = IDLE_ST;
                end
            end
            default: begin
                state_d = IDLE_ST;
            end
        endcase

        if (busy && expire && !completing) begin
            aw_valid_d     = 1'b0;
            w_valid_d      = 1'b0;
            b_ready_d      = 1'b0;
            ar_valid_d     = 1'b0;
            r_ready_d      = 1'b0;
            resp_resp_d    = 2'b11;
            resp_data_d    = 32'd0;
            resp_timeout_d = 1'b1;
            resp_valid_d   = 1'b1;
            state_d        = RESP_ST;
        end
    end

    // Synchronous reset clears every flop, so a reset mid-transaction drops all
    // handshakes at that edge and discards the pending command.
    always_ff @(posedge SysClk_ClkIn) begin
        if (!SysRstN_RstIn) begin
            state_q        <= IDLE_ST;
            cmd_ready_q    <= 1'b0;
            aw_valid_q     <= 1'b0;
            w_valid_q      <= 1'b0;
            b_ready_q      <= 1'b0;
            ar_valid_q     <= 1'b0;
            r_ready_q      <= 1'b0;
            addr_q         <= 16'd0;
            wdata_q        <= 32'd0;
            strobe_q       <= 4'd0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= 32'd0;
            resp_resp_q    <= 2'b00;
            resp_timeout_q <= 1'b0;
            timer_q        <= 16'd0;
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= cmd_ready_d;
            aw_valid_q     <= aw_valid_d;
            w_valid_q      <= w_valid_d;
            b_ready_q      <= b_ready_d;
            ar_valid_q     <= ar_valid_d;
            r_ready_q      <= r_ready_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            strobe_q       <= strobe_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_resp_q    <= resp_resp_d;
            resp_timeout_q <= resp_timeout_d;
            timer_q        <= timer_d;
        end
    end

    assign CmdReady_RdyOut            = cmd_ready_q;
    assign RespValid_ValOut           = resp_valid_q;
    assign RespData_DatOut            = resp_data_q;
    assign RespResponse_DatOut        = resp_resp_q;
    assign RespTimeout_ErrOut         = resp_timeout_q;
    assign AxiWriteAddrValid_ValOut   = aw_valid_q;
    assign AxiWriteAddrAddress_AdrOut = addr_q;
    assign AxiWriteAddrProt_DatOut    = 3'b000;
    assign AxiWriteDataValid_ValOut   = w_valid_q;
    assign AxiWriteDataData_DatOut    = wdata_q;
    assign AxiWriteDataStrobe_DatOut  = strobe_q;
    assign AxiWriteRespReady_RdyOut   = b_ready_q;
    assign AxiReadAddrValid_ValOut    = ar_valid_q;
    assign AxiReadAddrAddress_AdrOut  = addr_q;
    assign AxiReadAddrProt_DatOut     = 3'b000;
    assign AxiReadDataReady_RdyOut    = r_ready_q;

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// tb_axi_lite_reg_master
// Purpose: directed self-checking bench for axi_lite_reg_master, playing the AXI4-Lite
// slave and the command/response user by hand, cycle by cycle.
// Ports: none (top-level bench).
module tb_axi_lite_reg_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = 16'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [1:0]  resp_resp;
    logic        resp_timeout;
    logic        aw_valid;
    logic        aw_ready = 1'b0;
    logic [15:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        w_valid;
    logic        w_ready = 1'b0;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [1:0]  b_resp = 2'b00;
    logic        ar_valid;
    logic        ar_ready = 1'b0;
    logic [15:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        r_valid = 1'b0;
    logic        r_ready;
    logic [1:0]  r_resp = 2'b00;
    logic [31:0] r_data = 32'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_lite_reg_master #(.TimeoutCycles_Gen(16'd16)) dut (
        .SysClk_ClkIn               (clk),
        .SysRstN_RstIn              (rst_n),
        .CmdValid_ValIn             (cmd_valid),
        .CmdReady_RdyOut            (cmd_ready),
        .CmdWrite_EnIn              (cmd_write),
        .CmdAddress_AdrIn           (cmd_addr),
        .CmdData_DatIn              (cmd_data),
        .RespValid_ValOut           (resp_valid),
        .RespReady_RdyIn            (resp_ready),
        .RespData_DatOut            (resp_data),
        .RespResponse_DatOut        (resp_resp),
        .RespTimeout_ErrOut         (resp_timeout),
        .AxiWriteAddrValid_ValOut   (aw_valid),
        .AxiWriteAddrReady_RdyIn    (aw_ready),
        .AxiWriteAddrAddress_AdrOut (aw_addr),
        .AxiWriteAddrProt_DatOut    (aw_prot),
        .AxiWriteDataValid_ValOut   (w_valid),
        .AxiWriteDataReady_RdyIn    (w_ready),
        .AxiWriteDataData_DatOut    (w_data),
        .AxiWriteDataStrobe_DatOut  (w_strb),
        .AxiWriteRespValid_ValIn    (b_valid),
        .AxiWriteRespReady_RdyOut   (b_ready),
        .AxiWriteRespResponse_DatIn (b_resp),
        .AxiReadAddrValid_ValOut    (ar_valid),
        .AxiReadAddrReady_RdyIn     (ar_ready),
        .AxiReadAddrAddress_AdrOut  (ar_addr),
        .AxiReadAddrProt_DatOut     (ar_prot),
        .AxiReadDataValid_ValIn     (r_valid),
        .AxiReadDataReady_RdyOut    (r_ready),
        .AxiReadDataResponse_DatIn  (r_resp),
        .AxiReadDataData_DatIn      (r_data)
    );

    // Advance one clock edge; outputs are sampled and inputs changed 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for exactly one edge (caller guarantees CmdReady is high).
    task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Accept the pending result with a one-cycle RespReady pulse.
    task automatic ack_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_cmd_ready got %0b want 0", cmd_ready);
        end
        checks++;
        if ({aw_valid, w_valid, b_ready, ar_valid, r_ready, resp_valid} !== 6'b0) begin
            failures++; $display("[TB] FAIL reset_handshakes got %b want 000000",
                {aw_valid, w_valid, b_ready, ar_valid, r_ready, resp_valid});
        end
        checks++;
        if ({resp_data, resp_resp, resp_timeout, aw_addr, w_data, w_strb} !== 87'd0) begin
            failures++; $display("[TB] FAIL reset_data got nonzero data outputs, want all 0");
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_release_cmd_ready got %0b want 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        issue(1'b1, 16'h0008, 32'h0000_00F1);
        checks++;
        if ({aw_valid, w_valid, cmd_ready} !== 3'b110) begin
            failures++; $display("[TB] FAIL wr_valids_rise got %b want 110", {aw_valid, w_valid, cmd_ready});
        end
        checks++;
        if (aw_addr !== 16'h0008 || w_data !== 32'h0000_00F1 || w_strb !== 4'hF || aw_prot !== 3'b000) begin
            failures++; $display("[TB] FAIL wr_payload got addr %h data %h strb %h prot %b want 0008 000000f1 f 000",
                aw_addr, w_data, w_strb, aw_prot);
        end
        tick();
        checks++;
        if ({aw_valid, w_valid} !== 2'b11) begin
            failures++; $display("[TB] FAIL wr_valids_held got %b want 11", {aw_valid, w_valid});
        end
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        tick();
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        checks++;
        if ({aw_valid, w_valid, b_ready} !== 3'b001) begin
            failures++; $display("[TB] FAIL wr_after_aw_w got %b want 001", {aw_valid, w_valid, b_ready});
        end
        b_valid = 1'b1;
        b_resp  = 2'b00;
        tick();
        b_valid = 1'b0;
        checks++;
        if ({b_ready, resp_valid, resp_resp, resp_timeout} !== 5'b01000 || resp_data !== 32'd0) begin
            failures++; $display("[TB] FAIL wr_resp got bready %0b valid %0b resp %b to %0b data %h want 0 1 00 0 0",
                b_ready, resp_valid, resp_resp, resp_timeout, resp_data);
        end
        ack_resp();
        checks++;
        if ({resp_valid, cmd_ready} !== 2'b01) begin
            failures++; $display("[TB] FAIL wr_done got %b want 01", {resp_valid, cmd_ready});
        end
    endtask

    task automatic test_read_okay();
        issue(1'b0, 16'h0010, 32'hFFFF_FFFF);
        checks++;
        if (ar_valid !== 1'b1 || ar_addr !== 16'h0010 || aw_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL rd_ar got arvalid %0b addr %h awvalid %0b want 1 0010 0",
                ar_valid, ar_addr, aw_valid);
        end
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        checks++;
        if ({ar_valid, r_ready} !== 2'b01) begin
            failures++; $display("[TB] FAIL rd_after_ar got %b want 01", {ar_valid, r_ready});
        end
        r_valid = 1'b1;
        r_data  = 32'h0000_0100;
        r_resp  = 2'b00;
        tick();
        r_valid = 1'b0;
        checks++;
        if ({r_ready, resp_valid} !== 2'b01 || resp_data !== 32'h0000_0100 || resp_resp !== 2'b00) begin
            failures++; $display("[TB] FAIL rd_okay got rready %0b valid %0b data %h resp %b want 0 1 00000100 00",
                r_ready, resp_valid, resp_data, resp_resp);
        end
        ack_resp();
    endtask

    task automatic test_read_slverr();
        issue(1'b0, 16'h0004, 32'd0);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        r_valid = 1'b1;
        r_data  = 32'hDEAD_BEEF;
        r_resp  = 2'b10;
        tick();
        r_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_resp !== 2'b10 || resp_data !== 32'hDEAD_BEEF || resp_timeout !== 1'b0) begin
            failures++; $display("[TB] FAIL rd_slverr got valid %0b resp %b data %h to %0b want 1 10 deadbeef 0",
                resp_valid, resp_resp, resp_data, resp_timeout);
        end
        ack_resp();
    endtask

    task automatic test_split_write();
        issue(1'b1, 16'h000C, 32'h1234_5678);
        aw_ready = 1'b1;
        tick();
        aw_ready = 1'b0;
        checks++;
        if ({aw_valid, w_valid, b_ready} !== 3'b010 || w_data !== 32'h1234_5678) begin
            failures++; $display("[TB] FAIL split_aw_only got %b data %h want 010 12345678",
                {aw_valid, w_valid, b_ready}, w_data);
        end
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        checks++;
        if ({aw_valid, w_valid, b_ready} !== 3'b001) begin
            failures++; $display("[TB] FAIL split_w_done got %b want 001", {aw_valid, w_valid, b_ready});
        end
        b_valid = 1'b1;
        b_resp  = 2'b11;
        tick();
        b_valid = 1'b0;
        b_resp  = 2'b00;
        checks++;
        if (resp_valid !== 1'b1 || resp_resp !== 2'b11 || resp_timeout !== 1'b0) begin
            failures++; $display("[TB] FAIL split_decerr got valid %0b resp %b to %0b want 1 11 0",
                resp_valid, resp_resp, resp_timeout);
        end
        ack_resp();
    endtask

    task automatic test_timeout();
        issue(1'b1, 16'h0030, 32'hA5A5_A5A5);
        for (int i = 1; i < 16; i++) tick();
        checks++;
        if ({aw_valid, w_valid, resp_valid} !== 3'b110) begin
            failures++; $display("[TB] FAIL timeout_early got %b want 110 at cycle 15", {aw_valid, w_valid, resp_valid});
        end
        tick();
        checks++;
        if ({aw_valid, w_valid, resp_valid} !== 3'b001) begin
            failures++; $display("[TB] FAIL timeout_abort got %b want 001 at cycle 16", {aw_valid, w_valid, resp_valid});
        end
        checks++;
        if (resp_resp !== 2'b11 || resp_timeout !== 1'b1 || resp_data !== 32'd0) begin
            failures++; $display("[TB] FAIL timeout_resp got resp %b to %0b data %h want 11 1 0",
                resp_resp, resp_timeout, resp_data);
        end
        ack_resp();
        checks++;
        if ({resp_valid, cmd_ready} !== 2'b01) begin
            failures++; $display("[TB] FAIL timeout_cmd_ready got %b want 01", {resp_valid, cmd_ready});
        end
    endtask

    task automatic test_resp_backpressure();
        issue(1'b0, 16'h0018, 32'd0);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        r_valid = 1'b1;
        r_data  = 32'hCAFE_0001;
        r_resp  = 2'b00;
        tick();
        r_valid = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 16'h0020;
        cmd_data  = 32'h55AA_55AA;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({resp_valid, cmd_ready, aw_valid} !== 3'b100 || resp_data !== 32'hCAFE_0001) begin
                failures++; $display("[TB] FAIL bp_hold_%0d got %b data %h want 100 cafe0001",
                    i, {resp_valid, cmd_ready, aw_valid}, resp_data);
            end
        end
        ack_resp();
        checks++;
        if ({resp_valid, cmd_ready, aw_valid} !== 3'b010) begin
            failures++; $display("[TB] FAIL bp_release got %b want 010", {resp_valid, cmd_ready, aw_valid});
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({aw_valid, w_valid, cmd_ready} !== 3'b110 || aw_addr !== 16'h0020) begin
            failures++; $display("[TB] FAIL bp_second_cmd got %b addr %h want 110 0020",
                {aw_valid, w_valid, cmd_ready}, aw_addr);
        end
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        tick();
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b1;
        tick();
        b_valid = 1'b0;
        ack_resp();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 16'h0040, 32'd0);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        checks++;
        if (r_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL rst_mid_setup got rready %0b want 1", r_ready);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({ar_valid, r_ready, resp_valid, cmd_ready} !== 4'b0000) begin
            failures++; $display("[TB] FAIL rst_mid_drop got %b want 0000", {ar_valid, r_ready, resp_valid, cmd_ready});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, resp_valid} !== 2'b10) begin
            failures++; $display("[TB] FAIL rst_mid_release got %b want 10", {cmd_ready, resp_valid});
        end
    endtask

    initial begin
        $display("[TB] starting axi_lite_reg_master bench");
        test_reset();
        test_write();
        test_read_okay();
        test_read_slverr();
        test_split_write();
        test_timeout();
        test_resp_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
